// File: rtl/jtag_uart_pkg.sv
// Shared register map, bit positions and sizing helper for the JTAG UART FIFO slave.
package jtag_uart_pkg;

    localparam logic [1:0] ADDR_DATA    = 2'd0;
    localparam logic [1:0] ADDR_CONTROL = 2'd1;

    localparam int RE_BIT     = 0;
    localparam int WE_BIT     = 1;
    localparam int LB_BIT     = 2;
    localparam int RI_BIT     = 8;
    localparam int WI_BIT     = 9;
    localparam int OVF_BIT    = 14;
    localparam int RVALID_BIT = 15;

    localparam int LEVEL_LSB = 16;

    // A level must represent 0..DEPTH inclusive, hence one bit more than the pointer.
    function automatic int level_w(input int depth);
        return $clog2(depth) + 1;
    endfunction

endpackage

// File: rtl/jtag_uart_sync_fifo.sv
// Single-clock FIFO with occupancy level; push is ignored when full, pop when empty.
module jtag_uart_sync_fifo
    import jtag_uart_pkg::*;
#(
    parameter int W     = 8,
    parameter int DEPTH = 64
) (
    input  logic                      clk,
    input  logic                      reset,
    input  logic                      push,
    input  logic [W-1:0]              push_data,
    input  logic                      pop,
    output logic [W-1:0]              pop_data,
    output logic                      full,
    output logic                      empty,
    output logic [level_w(DEPTH)-1:0] level
);

    localparam int AW = $clog2(DEPTH);
    localparam int LW = level_w(DEPTH);

    logic [W-1:0]  mem_q [DEPTH];
    logic [AW-1:0] wr_ptr_q, wr_ptr_d;
    logic [AW-1:0] rd_ptr_q, rd_ptr_d;
    logic [LW-1:0] level_q, level_d;
    logic          push_ok, pop_ok;

    assign full     = (level_q == LW'(DEPTH));
    assign empty    = (level_q == '0);
    assign level    = level_q;
    assign pop_data = mem_q[rd_ptr_q];

    // Pointers wrap naturally because DEPTH is a power of two.
    always_comb begin
        push_ok  = push && !full;
        pop_ok   = pop && !empty;
        wr_ptr_d = wr_ptr_q + AW'(push_ok);
        rd_ptr_d = rd_ptr_q + AW'(pop_ok);
        level_d  = level_q + LW'(push_ok) - LW'(pop_ok);
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
            level_q  <= '0;
        end else begin
            wr_ptr_q <= wr_ptr_d;
            rd_ptr_q <= rd_ptr_d;
            level_q  <= level_d;
        end
    end

    always_ff @(posedge clk) begin
        if (push_ok) begin
            mem_q[wr_ptr_q] <= push_data;
        end
    end

endmodule

// File: rtl/jtag_uart_fifo_slave.sv
// JTAG UART Avalon-MM slave with TX/RX FIFOs, status/control register and level interrupt.
// Optional internal TX->RX loopback is built when JTAG_UART_LOOPBACK_EN is defined.
module jtag_uart_fifo_slave
    import jtag_uart_pkg::*;
#(
    parameter int DATA_W   = 8,
    parameter int TX_DEPTH = 64,
    parameter int RX_DEPTH = 64
) (
    input  logic              clk,
    input  logic              reset,
    input  logic [1:0]        avs_controlSlave_address,
    input  logic              avs_controlSlave_read,
    input  logic              avs_controlSlave_write,
    input  logic [31:0]       avs_controlSlave_writedata,
    output logic [31:0]       avs_controlSlave_readdata,
    output logic              avs_controlSlave_irq,
    output logic [DATA_W-1:0] tx_data,
    output logic              tx_valid,
    input  logic              tx_ready,
    input  logic [DATA_W-1:0] rx_data,
    input  logic              rx_valid,
    output logic              rx_ready
);

    localparam int TX_LW = level_w(TX_DEPTH);
    localparam int RX_LW = level_w(RX_DEPTH);

    logic              tx_push, tx_pop, tx_full, tx_empty;
    logic [DATA_W-1:0] tx_head;
    logic [TX_LW-1:0]  tx_level, tx_space;
    logic              rx_push, rx_pop, rx_full, rx_empty;
    logic [DATA_W-1:0] rx_head, rx_push_data;
    logic [RX_LW-1:0]  rx_level, rx_level_after;

    logic [31:0] readdata_q, readdata_d;
    logic        irq_q, irq_d;
    logic        re_q, re_d;
    logic        we_q, we_d;
    logic        ovf_q, ovf_d;
    logic        data_wr, ctrl_wr, data_rd, ri, wi;
    logic        unused_wd;
`ifdef JTAG_UART_LOOPBACK_EN
    logic        lb_q, lb_d;
    logic        lb_pop;
`endif

    assign unused_wd = ^avs_controlSlave_writedata;

    always_comb begin
        data_wr = avs_controlSlave_write && (avs_controlSlave_address == ADDR_DATA);
        ctrl_wr = avs_controlSlave_write && (avs_controlSlave_address == ADDR_CONTROL);
        // A write in the same cycle wins: the read still returns status but never pops.
        data_rd = avs_controlSlave_read && !avs_controlSlave_write &&
                  (avs_controlSlave_address == ADDR_DATA);

        tx_push        = data_wr && !tx_full;
        rx_pop         = data_rd && !rx_empty;
        tx_space       = TX_LW'(TX_DEPTH) - tx_level;
        rx_level_after = rx_level - RX_LW'(rx_pop);

        ri    = re_q && (rx_level != '0);
        wi    = we_q && (tx_space >= TX_LW'(TX_DEPTH / 2));
        irq_d = ri || wi;

        re_d  = re_q;
        we_d  = we_q;
        ovf_d = ovf_q;
`ifdef JTAG_UART_LOOPBACK_EN
        lb_d  = lb_q;
`endif
        if (ctrl_wr) begin
            re_d = avs_controlSlave_writedata[RE_BIT];
            we_d = avs_controlSlave_writedata[WE_BIT];
`ifdef JTAG_UART_LOOPBACK_EN
            lb_d = avs_controlSlave_writedata[LB_BIT];
`endif
            if (avs_controlSlave_writedata[OVF_BIT]) begin
                ovf_d = 1'b0;
            end
        end
        if (data_wr && tx_full) begin
            ovf_d = 1'b1;
        end

        readdata_d = readdata_q;
        if (avs_controlSlave_read) begin
            readdata_d = '0;
            case (avs_controlSlave_address)
                ADDR_DATA: begin
                    readdata_d[LEVEL_LSB +: 16] = 16'(rx_level_after);
                    if (rx_pop) begin
                        readdata_d[DATA_W-1:0]  = rx_head;
                        readdata_d[RVALID_BIT]  = 1'b1;
                    end
                end
                ADDR_CONTROL: begin
                    readdata_d[LEVEL_LSB +: 16] = 16'(tx_space);
                    readdata_d[OVF_BIT]         = ovf_q;
                    readdata_d[WI_BIT]          = wi;
                    readdata_d[RI_BIT]          = ri;
                    readdata_d[WE_BIT]          = we_q;
                    readdata_d[RE_BIT]          = re_q;
`ifdef JTAG_UART_LOOPBACK_EN
                    readdata_d[LB_BIT]          = lb_q;
`endif
                end
                default: ;
            endcase
        end
    end

`ifdef JTAG_UART_LOOPBACK_EN
    // Loopback hides both external streams and moves one char per cycle TX->RX.
    always_comb begin
        lb_pop       = lb_q && !tx_empty && !rx_full;
        tx_valid     = !lb_q && !tx_empty;
        rx_ready     = !lb_q && !rx_full;
        tx_pop       = lb_q ? lb_pop : (tx_valid && tx_ready);
        rx_push      = lb_q ? lb_pop : (rx_valid && rx_ready);
        rx_push_data = lb_q ? tx_head : rx_data;
    end
`else
    always_comb begin
        tx_valid     = !tx_empty;
        rx_ready     = !rx_full;
        tx_pop       = tx_valid && tx_ready;
        rx_push      = rx_valid && rx_ready;
        rx_push_data = rx_data;
    end
`endif

    assign tx_data                   = tx_head;
    assign avs_controlSlave_readdata = readdata_q;
    assign avs_controlSlave_irq      = irq_q;

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            readdata_q <= '0;
            irq_q      <= 1'b0;
            re_q       <= 1'b0;
            we_q       <= 1'b0;
            ovf_q      <= 1'b0;
`ifdef JTAG_UART_LOOPBACK_EN
            lb_q       <= 1'b0;
`endif
        end else begin
            readdata_q <= readdata_d;
            irq_q      <= irq_d;
            re_q       <= re_d;
            we_q       <= we_d;
            ovf_q      <= ovf_d;
`ifdef JTAG_UART_LOOPBACK_EN
            lb_q       <= lb_d;
`endif
        end
    end

    jtag_uart_sync_fifo #(
        .W     (DATA_W),
        .DEPTH (TX_DEPTH)
    ) u_tx_fifo (
        .clk       (clk),
        .reset     (reset),
        .push      (tx_push),
        .push_data (avs_controlSlave_writedata[DATA_W-1:0]),
        .pop       (tx_pop),
        .pop_data  (tx_head),
        .full      (tx_full),
        .empty     (tx_empty),
        .level     (tx_level)
    );

    jtag_uart_sync_fifo #(
        .W     (DATA_W),
        .DEPTH (RX_DEPTH)
    ) u_rx_fifo (
        .clk       (clk),
        .reset     (reset),
        .push      (rx_push),
        .push_data (rx_push_data),
        .pop       (rx_pop),
        .pop_data  (rx_head),
        .full      (rx_full),
        .empty     (rx_empty),
        .level     (rx_level)
    );

endmodule

// File: tb/tb_jtag_uart_fifo_slave.sv
// Directed self-checking bench for jtag_uart_fifo_slave (default 8-bit, 64-deep build).
module tb_jtag_uart_fifo_slave;

    localparam int DATA_W   = 8;
    localparam int TX_DEPTH = 64;
    localparam int RX_DEPTH = 64;

    logic              clk = 1'b0;
    logic              reset;
    logic [1:0]        address;
    logic              read;
    logic              write;
    logic [31:0]       writedata;
    logic [31:0]       readdata;
    logic              irq;
    logic [DATA_W-1:0] tx_data;
    logic              tx_valid;
    logic              tx_ready;
    logic [DATA_W-1:0] rx_data;
    logic              rx_valid;
    logic              rx_ready;

    int checks = 0;
    int errors = 0;

    always #5 clk = ~clk;

    jtag_uart_fifo_slave #(
        .DATA_W   (DATA_W),
        .TX_DEPTH (TX_DEPTH),
        .RX_DEPTH (RX_DEPTH)
    ) dut (
        .clk                        (clk),
        .reset                      (reset),
        .avs_controlSlave_address   (address),
        .avs_controlSlave_read      (read),
        .avs_controlSlave_write     (write),
        .avs_controlSlave_writedata (writedata),
        .avs_controlSlave_readdata  (readdata),
        .avs_controlSlave_irq       (irq),
        .tx_data                    (tx_data),
        .tx_valid                   (tx_valid),
        .tx_ready                   (tx_ready),
        .rx_data                    (rx_data),
        .rx_valid                   (rx_valid),
        .rx_ready                   (rx_ready)
    );

    // Bus tasks start and end on a falling edge; one rising edge latches the access.
    task automatic bus_write(input logic [1:0] a, input logic [31:0] d);
        address   = a;
        writedata = d;
        write     = 1'b1;
        @(negedge clk);
        write     = 1'b0;
    endtask

    task automatic bus_read(input logic [1:0] a);
        address = a;
        read    = 1'b1;
        @(negedge clk);
        read    = 1'b0;
    endtask

    task automatic test_reset;
        reset = 1'b1;
        repeat (2) @(negedge clk);
        checks++;
        if (readdata !== 32'h0 || irq !== 1'b0 || tx_valid !== 1'b0 || rx_ready !== 1'b1) begin
            errors++;
            $display("FAIL reset_outputs got rd=%h irq=%b txv=%b rxr=%b want rd=0 irq=0 txv=0 rxr=1",
                     readdata, irq, tx_valid, rx_ready);
        end
        reset = 1'b0;
        @(negedge clk);
        bus_read(2'd1);
        checks++;
        if (readdata !== 32'h0040_0000) begin
            errors++;
            $display("FAIL reset_control got %h want 00400000", readdata);
        end
    endtask

    task automatic test_rx_data;
        logic [31:0] exp_rd [4];
        logic [7:0]  chars  [3];
        exp_rd = '{32'h0002_8041, 32'h0001_8042, 32'h0000_8043, 32'h0000_0000};
        chars  = '{8'h41, 8'h42, 8'h43};
        rx_valid = 1'b1;
        for (int i = 0; i < 3; i++) begin
            rx_data = chars[i];
            @(negedge clk);
        end
        rx_valid = 1'b0;
        for (int i = 0; i < 4; i++) begin
            bus_read(2'd0);
            checks++;
            if (readdata !== exp_rd[i]) begin
                errors++;
                $display("FAIL rx_data_read%0d got %h want %h", i, readdata, exp_rd[i]);
            end
        end
    endtask

    task automatic test_tx_overflow;
        int bad;
        tx_ready = 1'b0;
        for (int i = 0; i < 65; i++) begin
            bus_write(2'd0, (i == 64) ? 32'h0000_00EE : 32'(8'h10 + i));
        end
        checks++;
        if (tx_valid !== 1'b1 || tx_data !== 8'h10) begin
            errors++;
            $display("FAIL tx_head got v=%b d=%h want v=1 d=10", tx_valid, tx_data);
        end
        bus_read(2'd1);
        checks++;
        if (readdata !== 32'h0000_4000) begin
            errors++;
            $display("FAIL tx_full_ovf got %h want 00004000", readdata);
        end
        bus_write(2'd1, 32'h0000_4000);
        bus_read(2'd1);
        checks++;
        if (readdata !== 32'h0000_0000) begin
            errors++;
            $display("FAIL ovf_clear got %h want 00000000", readdata);
        end
        bad = 0;
        tx_ready = 1'b1;
        for (int i = 0; i < 64; i++) begin
            if (tx_valid !== 1'b1 || tx_data !== 8'(8'h10 + i)) begin
                if (bad == 0) begin
                    $display("FAIL tx_drain at %0d got v=%b d=%h want v=1 d=%h",
                             i, tx_valid, tx_data, 8'(8'h10 + i));
                end
                bad++;
            end
            @(negedge clk);
        end
        checks++;
        if (bad != 0) errors++;
        tx_ready = 1'b0;
        checks++;
        if (tx_valid !== 1'b0) begin
            errors++;
            $display("FAIL tx_empty_after_drain got v=%b want 0", tx_valid);
        end
        bus_read(2'd1);
        checks++;
        if (readdata !== 32'h0040_0000) begin
            errors++;
            $display("FAIL tx_space_restored got %h want 00400000", readdata);
        end
    endtask

    task automatic test_irq;
        bus_write(2'd1, 32'h1);
        rx_data  = 8'h33;
        rx_valid = 1'b1;
        @(negedge clk);
        rx_valid = 1'b0;
        checks++;
        if (irq !== 1'b0) begin
            errors++;
            $display("FAIL irq_lag got %b want 0", irq);
        end
        @(negedge clk);
        checks++;
        if (irq !== 1'b1) begin
            errors++;
            $display("FAIL irq_ri_set got %b want 1", irq);
        end
        bus_read(2'd0);
        checks++;
        if (readdata !== 32'h0000_8033 || irq !== 1'b1) begin
            errors++;
            $display("FAIL irq_pop got rd=%h irq=%b want rd=00008033 irq=1", readdata, irq);
        end
        @(negedge clk);
        checks++;
        if (irq !== 1'b0) begin
            errors++;
            $display("FAIL irq_ri_clear got %b want 0", irq);
        end
        bus_write(2'd1, 32'h2);
        @(negedge clk);
        checks++;
        if (irq !== 1'b1) begin
            errors++;
            $display("FAIL irq_wi_set got %b want 1", irq);
        end
        bus_read(2'd1);
        checks++;
        if (readdata !== 32'h0040_0202) begin
            errors++;
            $display("FAIL control_wi got %h want 00400202", readdata);
        end
        bus_write(2'd1, 32'h0);
        @(negedge clk);
        checks++;
        if (irq !== 1'b0) begin
            errors++;
            $display("FAIL irq_wi_clear got %b want 0", irq);
        end
    endtask

    task automatic test_reserved;
        bus_write(2'd3, 32'h0000_4003);
        bus_read(2'd2);
        checks++;
        if (readdata !== 32'h0) begin
            errors++;
            $display("FAIL reserved_read got %h want 00000000", readdata);
        end
        bus_read(2'd1);
        checks++;
        if (readdata !== 32'h0040_0000) begin
            errors++;
            $display("FAIL reserved_write_ignored got %h want 00400000", readdata);
        end
    endtask

    task automatic test_rx_full;
        int          bad;
        logic [31:0] exp;
        rx_valid = 1'b1;
        for (int i = 0; i < 64; i++) begin
            rx_data = 8'(8'h80 + i);
            @(negedge clk);
        end
        rx_data = 8'hFF;
        checks++;
        if (rx_ready !== 1'b0) begin
            errors++;
            $display("FAIL rx_full_ready got %b want 0", rx_ready);
        end
        @(negedge clk);
        bus_read(2'd0);
        checks++;
        if (readdata !== 32'h003F_8080 || rx_ready !== 1'b1) begin
            errors++;
            $display("FAIL rx_full_pop got rd=%h rxr=%b want rd=003f8080 rxr=1", readdata, rx_ready);
        end
        @(negedge clk);
        rx_valid = 1'b0;
        checks++;
        if (rx_ready !== 1'b0) begin
            errors++;
            $display("FAIL rx_refill got rxr=%b want 0", rx_ready);
        end
        bad = 0;
        for (int k = 0; k < 64; k++) begin
            exp = (32'(63 - k) << 16) | 32'h8000 | ((k < 63) ? 32'(8'h81 + k) : 32'hFF);
            bus_read(2'd0);
            if (readdata !== exp) begin
                if (bad == 0) $display("FAIL rx_full_drain at %0d got %h want %h", k, readdata, exp);
                bad++;
            end
        end
        checks++;
        if (bad != 0) errors++;
        bus_read(2'd0);
        checks++;
        if (readdata !== 32'h0) begin
            errors++;
            $display("FAIL rx_empty_after_drain got %h want 00000000", readdata);
        end
    endtask

`ifdef JTAG_UART_LOOPBACK_EN
    task automatic test_loopback;
        int bad;
        bad = 0;
        bus_write(2'd1, 32'h4);
        bus_read(2'd1);
        checks++;
        if (readdata !== 32'h0040_0004 || rx_ready !== 1'b0) begin
            errors++;
            $display("FAIL lb_control got rd=%h rxr=%b want rd=00400004 rxr=0", readdata, rx_ready);
        end
        bus_write(2'd0, 32'h5A);
        for (int i = 0; i < 3; i++) begin
            if (tx_valid !== 1'b0) bad++;
            @(negedge clk);
        end
        bus_read(2'd0);
        checks++;
        if (readdata !== 32'h0000_805A || bad != 0 || tx_valid !== 1'b0) begin
            errors++;
            $display("FAIL lb_data got rd=%h txv_hits=%0d want rd=0000805a txv_hits=0", readdata, bad);
        end
        bus_write(2'd1, 32'h0);
    endtask
`endif

    initial begin
        reset     = 1'b1;
        address   = 2'd0;
        read      = 1'b0;
        write     = 1'b0;
        writedata = 32'h0;
        tx_ready  = 1'b0;
        rx_data   = '0;
        rx_valid  = 1'b0;
        test_reset();
        test_rx_data();
        test_tx_overflow();
        test_irq();
        test_reserved();
        test_rx_full();
`ifdef JTAG_UART_LOOPBACK_EN
        test_loopback();
`endif
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL watchdog expired");
        $fatal(1, "watchdog");
    end

endmodule
